mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 64x32 unified RAM between the pipeline's instruction-fetch
//  (IF) port and data-memory (DM) port. Grants one access per cycle and routes
//  synchronous read data back to the winning port. A starvation guard keeps fetch
//  from being locked out by back-to-back load/store traffic.
//  Sits between the pipeline's IF/MEM stages and the RAM macro.
// PARAMETERS
//  DATA_W      32  RAM word width
//  ADDR_W      6   word address width (64 entries)
//  STARVE_MAX  4   consecutive denied IF cycles before IF is forced to win
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset      in   1       asynchronous, active-low reset
//  if_req     in   1       fetch request (level, held until if_gnt)
//  if_addr    in   ADDR_W  fetch word address
//  if_gnt     out  1       fetch accepted this cycle (combinational)
//  if_rvalid  out  1       if_rdata valid (registered)
//  if_rdata   out  DATA_W  fetched instruction
//  dm_req     in   1       data request (level, held until dm_gnt)
//  dm_we      in   1       1 = store, 0 = load
//  dm_addr    in   ADDR_W  data word address
//  dm_wdata   in   DATA_W  store data
//  dm_gnt     out  1       data access accepted this cycle (combinational)
//  dm_rvalid  out  1       dm_rdata valid, loads only (registered)
//  dm_rdata   out  DATA_W  load data
//  ram_en     out  1       RAM enable
//  ram_we     out  1       RAM write enable
//  ram_addr   out  ADDR_W  RAM address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data, valid one cycle after ram_en&~ram_we
//  starve_cnt out  3       current IF starvation count (debug)
// BEHAVIOUR
//  - Reset (reset=0, async): rd_owner=NONE, starve_cnt=0, if_rvalid=dm_rvalid=0.
//    While reset is low, if_gnt, dm_gnt, ram_en and ram_we are forced to 0.
//  - Grant (combinational, per cycle): at most one of if_gnt/dm_gnt is high.
//    Only dm_req -> DM. Only if_req -> IF. Both -> DM, unless starve_cnt==STARVE_MAX,
//    in which case IF wins.
//  - RAM drive: ram_en = if_gnt|dm_gnt; ram_we = dm_gnt&dm_we; ram_addr/ram_wdata muxed
//    from the winner (ram_wdata = dm_wdata regardless).
//  - starve_cnt: clears to 0 when IF is granted or if_req=0. Increments when
//    if_req&~if_gnt. Saturates at STARVE_MAX.
//  - Read return, latency 1: rd_owner register <= IF if if_gnt; DM if dm_gnt&~dm_we;
//    else NONE. if_rvalid = (rd_owner==IF), dm_rvalid = (rd_owner==DM).
//    if_rdata = dm_rdata = ram_rdata (unqualified; consumers use rvalid).
//  - A store gives no rvalid; dm_gnt is its only acknowledge.
//  - Pipelined accesses: a new grant may issue every cycle. Back-to-back reads return
//    in order, one per cycle.
//  - Addresses are ADDR_W wide; no range check, and wrap is implicit.
//  - Reset mid-read: a pending rvalid is dropped, and no rvalid appears after reset
//    is released.
//  - A requester changing its address while denied is legal; the address sampled is
//    the one present in the grant cycle.
// TESTING
//  1 IF-only: if_req=1, addr 0..3, RAM preloaded with words 0x00000013+i -> if_gnt every
//    cycle; if_rvalid 1 cycle later with 0x13,0x14,0x15,0x16 in order.
//  2 Store then load: dm store 0xDEADBEEF to addr 10, next cycle load addr 10 ->
//    dm_rvalid one cycle after the load grant, dm_rdata=0xDEADBEEF; no rvalid for the store.
//  3 Contention: if_req and dm_req both held high -> DM granted 4 cycles,
//    starve_cnt 1..4, IF granted on the 5th cycle, counter back to 0; pattern repeats.
//  4 Both request, starve_cnt<4 -> only dm_gnt high; never both grants in any cycle (assertion).
//  5 Reset mid-read: IF granted at addr 5, reset pulled low before next edge ->
//    if_rvalid stays 0, grants 0 while low; after release IF re-fetches addr 5 normally.
//  6 Idle: no requests for 10 cycles -> ram_en=0, rvalids=0, starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between the fetch (IF) and data (DM) ports.
// DM normally wins a conflict; a saturating starvation counter forces an IF win.
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [2:0]        starve_cnt
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    owner_e     rd_owner_q;
    owner_e     rd_owner_d;
    logic [2:0] starve_q;
    logic [2:0] starve_d;
    logic       if_gnt_s;
    logic       dm_gnt_s;
    logic       if_force_s;

    // Grant decision; the reset term keeps the RAM quiet while reset is held low.
    always_comb begin
        if_gnt_s   = 1'b0;
        dm_gnt_s   = 1'b0;
        if_force_s = (starve_q == STARVE_LIM);
        if (!reset) begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end else if (dm_req && !(if_req && if_force_s)) begin
            dm_gnt_s = 1'b1;
        end else if (if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
        end
    end

    // RAM drive from the winner; write data always comes from the DM port.
    always_comb begin
        ram_en    = if_gnt_s | dm_gnt_s;
        ram_we    = dm_gnt_s & dm_we;
        ram_wdata = dm_wdata;
        if (dm_gnt_s) begin
            ram_addr = dm_addr;
        end else begin
            ram_addr = if_addr;
        end
    end

    // Next starvation count and read-return owner.
    always_comb begin
        starve_d   = starve_q;
        rd_owner_d = OWN_NONE;
        if (!if_req || if_gnt_s) begin
            starve_d = 3'd0;
        end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + 3'd1;
        end else begin
            starve_d = starve_q;
        end
        if (if_gnt_s) begin
            rd_owner_d = OWN_IF;
        end else if (dm_gnt_s && !dm_we) begin
            rd_owner_d = OWN_DM;
        end else begin
            rd_owner_d = OWN_NONE;
        end
    end

    // State registers; async reset drops any read still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner_q <= OWN_NONE;
            starve_q   <= 3'd0;
        end else begin
            rd_owner_q <= rd_owner_d;
            starve_q   <= starve_d;
        end
    end

    // Output decode; read data is shared and qualified only by the rvalids.
    always_comb begin
        if_gnt     = if_gnt_s;
        dm_gnt     = dm_gnt_s;
        starve_cnt = starve_q;
        if_rdata   = ram_rdata;
        dm_rdata   = ram_rdata;
        case (rd_owner_q)
            OWN_IF: begin
                if_rvalid = 1'b1;
                dm_rvalid = 1'b0;
            end
            OWN_DM: begin
                if_rvalid = 1'b0;
                dm_rvalid = 1'b1;
            end
            default: begin
                if_rvalid = 1'b0;
                dm_rvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural RAM, a per-cycle reference
// model of the arbitration rules, and literal checks for each scenario.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [5:0]  if_addr = 6'd0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [5:0]  dm_addr = 6'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'd0;
    logic [2:0]  starve_cnt;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    int          m_starve = 0;
    int          m_pend = 0;
    logic [31:0] m_data = 32'd0;

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(6), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Synchronous single-port RAM behaviour.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Reference model: check outputs mid-cycle, then commit what the next edge does.
    always @(negedge clk) begin
        bit win_if;
        bit win_dm;
        chk("one_grant", {31'd0, if_gnt & dm_gnt}, 32'd0);
        if (!reset) begin
            chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
            chk("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
            chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
            chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
            chk("rst_starve", {29'd0, starve_cnt}, 32'd0);
            chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
            chk("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
            m_starve = 0;
            m_pend = 0;
        end else begin
            chk("m_if_rvalid", {31'd0, if_rvalid}, (m_pend == 1) ? 32'd1 : 32'd0);
            chk("m_dm_rvalid", {31'd0, dm_rvalid}, (m_pend == 2) ? 32'd1 : 32'd0);
            if (m_pend == 1) chk("m_if_rdata", if_rdata, m_data);
            if (m_pend == 2) chk("m_dm_rdata", dm_rdata, m_data);
            win_if = if_req && (!dm_req || m_starve == 4);
            win_dm = dm_req && !win_if;
            chk("m_if_gnt", {31'd0, if_gnt}, {31'd0, win_if});
            chk("m_dm_gnt", {31'd0, dm_gnt}, {31'd0, win_dm});
            chk("m_ram_en", {31'd0, ram_en}, {31'd0, win_if | win_dm});
            chk("m_ram_we", {31'd0, ram_we}, {31'd0, win_dm & dm_we});
            chk("m_starve", {29'd0, starve_cnt}, 32'(m_starve));
            if (win_if) chk("m_ram_addr", {26'd0, ram_addr}, {26'd0, if_addr});
            if (win_dm) chk("m_ram_addr", {26'd0, ram_addr}, {26'd0, dm_addr});
            if (win_dm && dm_we) chk("m_ram_wdata", ram_wdata, dm_wdata);
            if (win_if) begin
                m_pend = 1;
                m_data = ref_mem[if_addr];
            end else if (win_dm && !dm_we) begin
                m_pend = 2;
                m_data = ref_mem[dm_addr];
            end else begin
                m_pend = 0;
            end
            if (win_dm && dm_we) ref_mem[dm_addr] = dm_wdata;
            if (!if_req || win_if) m_starve = 0;
            else if (m_starve < 4) m_starve = m_starve + 1;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h0000_0013 + 32'(i);
            ref_mem[i] = 32'h0000_0013 + 32'(i);
        end
        repeat (2) next_cyc();
        reset = 1'b1;
        next_cyc();

        // IF-only stream, addresses 0..3
        for (int k = 0; k < 5; k++) begin
            if_req  = (k < 4);
            if_addr = 6'(k);
            @(negedge clk);
            if (k < 4) chk("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
            if (k > 0) begin
                chk("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
                chk("t1_if_rdata", if_rdata, 32'h0000_0013 + 32'(k - 1));
            end
            next_cyc();
        end

        // Store then load at address 10
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 6'd10; dm_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t2_st_gnt", {31'd0, dm_gnt}, 32'd1);
        next_cyc();
        dm_we = 1'b0;
        @(negedge clk);
        chk("t2_ld_gnt", {31'd0, dm_gnt}, 32'd1);
        chk("t2_st_norv", {31'd0, dm_rvalid}, 32'd0);
        next_cyc();
        dm_req = 1'b0;
        @(negedge clk);
        chk("t2_ld_rvalid", {31'd0, dm_rvalid}, 32'd1);
        chk("t2_ld_rdata", dm_rdata, 32'hDEAD_BEEF);
        next_cyc();

        // Contention: IF forced through on every fifth cycle
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 6'd30; if_req = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if_addr = 6'(20 + c);
            @(negedge clk);
            chk("t3_starve", {29'd0, starve_cnt}, 32'(c % 5));
            chk("t3_if_gnt", {31'd0, if_gnt}, (c % 5 == 4) ? 32'd1 : 32'd0);
            chk("t3_dm_gnt", {31'd0, dm_gnt}, (c % 5 == 4) ? 32'd0 : 32'd1);
            next_cyc();
        end
        dm_req = 1'b0; if_req = 1'b0;
        next_cyc();

        // Reset while an IF read is in flight
        if_req = 1'b1; if_addr = 6'd5;
        @(negedge clk);
        chk("t5_if_gnt", {31'd0, if_gnt}, 32'd1);
        #2 reset = 1'b0;
        next_cyc();
        @(negedge clk);
        chk("t5_no_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("t5_no_gnt", {31'd0, if_gnt}, 32'd0);
        next_cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_post_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("t5_regnt", {31'd0, if_gnt}, 32'd1);
        next_cyc();
        if_req = 1'b0;
        @(negedge clk);
        chk("t5_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("t5_rdata", if_rdata, 32'h0000_0018);
        next_cyc();

        // Idle
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t6_ram_en", {31'd0, ram_en}, 32'd0);
            chk("t6_rvalids", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
            chk("t6_starve", {29'd0, starve_cnt}, 32'd0);
            next_cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
